addsub_pipe: RTL and testbench
==============================

ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24: operand and result width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter STAGES, default 2: pipeline depth in cycles, legal range 1..4, with WIDTH divisible by STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand beat present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: operand beat accepted this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: minuend or addend.
REQ-008 The block SHALL have port b, input, WIDTH bits: subtrahend or addend.
REQ-009 The block SHALL have port ctl, input, 1 bit: 0 computes a+b, 1 computes a-b.
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous pipeline clear.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result beat present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result beat.
REQ-013 The block SHALL have port sum, output, WIDTH bits: raw two's-complement result, a + (b XOR {ctl}) + ctl.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of the MSB (1 means no borrow in subtract mode).
REQ-015 The block SHALL have port ovf, output, 1 bit: signed overflow of the result.
REQ-016 The block SHALL have port mag, output, WIDTH bits: magnitude result.
REQ-017 The block SHALL have port neg, output, 1 bit: magnitude sign.

Function
REQ-018 Carry chain: the chain SHALL be split into STAGES segments of WIDTH/STAGES bits. Segment k SHALL be computed in pipeline stage k. The inter-segment carry and the not-yet-added operand bits SHALL be registered between stages.
REQ-019 Stage 0 carry-in SHALL equal ctl, and b SHALL be inverted when ctl=1.
REQ-020 Latency: a beat accepted at edge N SHALL present its result with out_valid=1 after edge N+STAGES when there is no stall.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-022 Stall: stall = out_valid AND NOT out_ready. While stalled, all stage registers SHALL hold their values, and the result outputs SHALL stay stable.
REQ-023 in_ready = NOT stall. A beat SHALL be accepted only when in_valid AND in_ready.
REQ-024 Bubbles: each stage SHALL carry its own valid bit, so empty stages advance without producing out_valid.
REQ-025 ovf SHALL be (a[MSB] == b'[MSB]) AND (sum[MSB] != a[MSB]), where b' is b after the ctl inversion.
REQ-026 When ctl=1 and cout=1: mag SHALL equal sum and neg SHALL be 0.
REQ-027 When ctl=1 and cout=0: mag SHALL equal (NOT sum)+1, truncated to WIDTH bits, and neg SHALL be 1.
REQ-028 When ctl=0: mag SHALL equal sum and neg SHALL be 0.
REQ-029 The mag and neg computation SHALL be combinational on the final stage registers and SHALL add no latency.
REQ-030 flush=1 SHALL clear all stage valid bits at the next edge, with no out_valid the following cycle.
REQ-031 flush SHALL override a simultaneous input acceptance; that beat is discarded and in_ready is still reported.
REQ-032 Boundary: a=b in subtract mode SHALL give sum=0, cout=1, mag=0, neg=0.
REQ-033 Boundary: a=0, b=0 in add mode SHALL give all outputs 0.
REQ-034 Boundary: a stall arriving in the same cycle as a new input SHALL block the input (in_ready=0), and no beat SHALL be lost or duplicated.

Reset
REQ-035 rst=1 SHALL asynchronously clear all stage valid bits and data registers, independent of clk.
REQ-036 During reset, out_valid SHALL be 0, sum, cout, ovf, mag and neg SHALL be 0, and in_ready SHALL be 1.
REQ-037 Reset asserted mid-operation SHALL drop all in-flight beats; the first accepted beat after deassertion SHALL emerge after STAGES cycles.

Configuration
REQ-038 Macro ADDSUB_PIPE_MAG_EN SHALL control the magnitude path.
REQ-039 With ADDSUB_PIPE_MAG_EN defined, mag and neg SHALL behave per REQ-026 to REQ-028.
REQ-040 Without ADDSUB_PIPE_MAG_EN, the magnitude logic SHALL be absent, mag and neg SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-041 Subtract, no borrow (WIDTH=8, STAGES=2): a=0x50, b=0x20, ctl=1 -> after 2 cycles sum=0x30, cout=1, mag=0x30, neg=0, ovf=0.
REQ-042 Subtract, borrow (WIDTH=8, STAGES=2): a=0x20, b=0x50, ctl=1 -> sum=0xD0, cout=0, mag=0x30, neg=1. With the macro undefined, mag=0 and neg=0.
REQ-043 Signed overflow (WIDTH=8): a=0x7F, b=0x01, ctl=0 -> sum=0x80, cout=0, ovf=1, mag=0x80, neg=0.
REQ-044 Backpressure: stream 6 beats with in_valid held high while out_ready=0 for cycles 3-5 -> in_ready=0 during the stall, all 6 results are delivered in order exactly once, and the outputs stay stable while stalled.
REQ-045 Flush and reset: with 2 beats in flight, assert flush for 1 cycle -> no out_valid. Repeat with rst pulsed asynchronously between edges -> outputs clear immediately, and the next beat has latency STAGES.
REQ-046 Sweep STAGES=1,3,4 with WIDTH=12 against a reference model, over 1000 random beats plus the corner values 0, all-ones and MSB-only -> bit-exact match on all outputs.

Source files
------------

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined adder/subtractor, carry chain split into STAGES segments.
// Define ADDSUB_PIPE_MAG_EN to build the magnitude/sign path.
module addsub_pipe #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctl,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  localparam int SEG = WIDTH / STAGES;
  localparam int L   = STAGES - 1;
  localparam int MSB = WIDTH - 1;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
`ifdef ADDSUB_PIPE_MAG_EN
  logic [STAGES-1:0] m_q, m_d;
`endif
  logic              stall;
  logic              accept;

  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  assign out_valid = v_q[L];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;

  // Stage k adds segment k on top of the partial sum from stage k-1.
  always_comb begin
    logic [SEG:0] r;
    r = seg_add(a[SEG-1:0], b[SEG-1:0] ^ {SEG{ctl}}, ctl);
    v_d[0] = accept;
    a_d[0] = a;
    b_d[0] = b ^ {WIDTH{ctl}};
    s_d[0] = '0;
    s_d[0][SEG-1:0] = r[SEG-1:0];
    c_d[0] = r[SEG];
`ifdef ADDSUB_PIPE_MAG_EN
    m_d[0] = ctl;
`endif
    for (int k = 1; k < STAGES; k++) begin
      r = seg_add(a_q[k-1][k*SEG +: SEG],
                  b_q[k-1][k*SEG +: SEG],
                  c_q[k-1]);
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = s_q[k-1];
      s_d[k][k*SEG +: SEG] = r[SEG-1:0];
      c_d[k] = r[SEG];
`ifdef ADDSUB_PIPE_MAG_EN
      m_d[k] = m_q[k-1];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else if (flush) begin
      v_q <= '0;
    end else if (!stall) begin
      v_q <= v_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
`ifdef ADDSUB_PIPE_MAG_EN
      m_q <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      c_q <= c_d;
`ifdef ADDSUB_PIPE_MAG_EN
      m_q <= m_d;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign sum  = s_q[L];
  assign cout = c_q[L];
  assign ovf  = (a_q[L][MSB] == b_q[L][MSB]) &
                (s_q[L][MSB] != a_q[L][MSB]);

`ifdef ADDSUB_PIPE_MAG_EN
  // A borrow in subtract mode means the raw result is negative.
  assign neg = m_q[L] & ~c_q[L];
  assign mag = neg ? (~s_q[L] + WIDTH'(1)) : s_q[L];
`else
  assign neg = 1'b0;
  assign mag = '0;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed vectors plus random traffic on four
// WIDTH/STAGES configurations, each checked against a scoreboard.
module tb_addsub_pipe;

  localparam int N = 4;
  localparam int WT [N] = '{8, 12, 12, 12};
  localparam int ST [N] = '{2, 1, 3, 4};

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic [63:0] mag;
    logic        neg;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic [7:0] m;
    logic       n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        ctl = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a_s = '0;
  logic [63:0] b_s = '0;

  logic [63:0] sum_a [N];
  logic [63:0] mag_a [N];
  logic        ir_a  [N];
  logic        ov_a  [N];
  logic        co_a  [N];
  logic        ovf_a [N];
  logic        ng_a  [N];

  res_t q [N][$];
  res_t prev [N];
  bit   pstall [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int W = WT[gi];
    logic [W-1:0] sum_w;
    logic [W-1:0] mag_w;
    addsub_pipe #(.WIDTH(W), .STAGES(ST[gi])) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir_a[gi]),
      .a(a_s[W-1:0]), .b(b_s[W-1:0]),
      .ctl(ctl), .flush(flush),
      .out_valid(ov_a[gi]), .out_ready(out_ready),
      .sum(sum_w), .cout(co_a[gi]), .ovf(ovf_a[gi]),
      .mag(mag_w), .neg(ng_a[gi])
    );
    assign sum_a[gi] = 64'(sum_w);
    assign mag_a[gi] = 64'(mag_w);
  end

  // Result from plain integer arithmetic on the operand values.
  function automatic res_t ref_model(
    input logic [63:0] ai, input logic [63:0] bi,
    input logic c, input int w
  );
    res_t r;
    longint unsigned m, av, bv;
    longint sa, sb, sr, lim;
    m  = (longint'(1) << w) - 1;
    av = ai & m;
    bv = bi & m;
    r.sum  = (c ? av - bv : av + bv) & m;
    r.cout = c ? (av >= bv) : ((av + bv) > m);
    sa  = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
    sb  = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
    sr  = c ? sa - sb : sa + sb;
    lim = longint'(1) << (w - 1);
    r.ovf = (sr >= lim) || (sr < -lim);
`ifdef ADDSUB_PIPE_MAG_EN
    if (c && av < bv) begin
      r.mag = bv - av;
      r.neg = 1'b1;
    end else begin
      r.mag = r.sum;
      r.neg = 1'b0;
    end
`else
    r.mag = '0;
    r.neg = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, want %h", nm, id, got, exp);
    end
  endtask

  task automatic clear_sb();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      pstall[i] = 1'b0;
    end
  endtask

  // Sampled at the falling edge, half a cycle from any active edge.
  task automatic mon();
    res_t got, e;
    for (int i = 0; i < N; i++) begin
      got.sum  = sum_a[i];
      got.cout = co_a[i];
      got.ovf  = ovf_a[i];
      got.mag  = mag_a[i];
      got.neg  = ng_a[i];
      if (rst) begin
        chk("reset out_valid", i, 64'(ov_a[i]), 64'd0);
        chk("reset in_ready", i, 64'(ir_a[i]), 64'd1);
        tests++;
        if (got !== '0) begin
          fails++;
          $display("FAIL reset outputs dut%0d: got %h, want 0", i, got);
        end
      end else begin
        chk("in_ready rule", i, 64'(ir_a[i]),
            64'(!(ov_a[i] && !out_ready)));
        if (pstall[i]) begin
          tests++;
          if (got !== prev[i] || !ov_a[i]) begin
            fails++;
            $display("FAIL stall hold dut%0d: got %h v=%b, want %h v=1",
                     i, got, ov_a[i], prev[i]);
          end
        end
        if (ov_a[i] && out_ready) begin
          tests++;
          if (q[i].size() == 0) begin
            fails++;
            $display("FAIL spurious beat dut%0d: got %h, want none", i, got);
          end else begin
            e = q[i].pop_front();
            if (got !== e) begin
              fails++;
              $display("FAIL result dut%0d: got %h, want %h", i, got, e);
            end
          end
        end
        if (in_valid && ir_a[i] && !flush)
          q[i].push_back(ref_model(a_s, b_s, ctl, WT[i]));
        if (flush) q[i].delete();
        pstall[i] = ov_a[i] && !out_ready && !flush;
        prev[i] = got;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return 64'h800;
      3:       return 64'h80;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    vec_t tv [9];
    logic [63:0] exp_s [$];
    logic [63:0] got_s [$];
    logic [7:0]  em;
    logic        en;
    int idx, nlow;

    tv[0] = '{8'h50, 8'h20, 1'b1, 8'h30, 1'b1, 1'b0, 8'h30, 1'b0};
    tv[1] = '{8'h20, 8'h50, 1'b1, 8'hD0, 1'b0, 1'b0, 8'h30, 1'b1};
    tv[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0};
    tv[3] = '{8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tv[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[6] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0};
    tv[7] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h01, 1'b1};
    tv[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};

    clear_sb();
    #1;
    chk("por out_valid", 0, 64'(ov_a[0]), 64'd0);
    chk("por in_ready", 0, 64'(ir_a[0]), 64'd1);
    chk("por sum", 0, sum_a[0], 64'd0);
    repeat (3) tick();
    rst = 1'b0;

    // Directed vectors on the 8-bit, 2-stage instance.
    for (int i = 0; i < 9; i++) begin
      a_s = 64'(tv[i].a);
      b_s = 64'(tv[i].b);
      ctl = tv[i].c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("vec early valid", 0, 64'(ov_a[0]), 64'd0);
      tick();
`ifdef ADDSUB_PIPE_MAG_EN
      em = tv[i].m;
      en = tv[i].n;
`else
      em = 8'h00;
      en = 1'b0;
`endif
      chk("vec out_valid", 0, 64'(ov_a[0]), 64'd1);
      chk("vec sum", 0, sum_a[0], 64'(tv[i].s));
      chk("vec cout", 0, 64'(co_a[0]), 64'(tv[i].co));
      chk("vec ovf", 0, 64'(ovf_a[0]), 64'(tv[i].ov));
      chk("vec mag", 0, mag_a[0], 64'(em));
      chk("vec neg", 0, 64'(ng_a[0]), 64'(en));
      tick();
      chk("vec bubble", 0, 64'(ov_a[0]), 64'd0);
    end

    // Backpressure: 6 beats, downstream stalls for cycles 3..5.
    idx = 0;
    nlow = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = (idx < 6);
      a_s = 64'(idx * 16 + 3);
      b_s = 64'(idx + 1);
      ctl = idx[0];
      #1;
      if (!ir_a[0]) nlow++;
      if (ov_a[0] && out_ready) got_s.push_back(sum_a[0]);
      if (in_valid && ir_a[0]) begin
        exp_s.push_back(ref_model(a_s, b_s, ctl, 8).sum);
        idx++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp delivered", 0, 64'(got_s.size()), 64'd6);
    chk("bp stall cycles", 0, 64'(nlow), 64'd3);
    for (int j = 0; j < 6; j++)
      chk("bp order", 0, got_s[j], exp_s[j]);

    // Flush with two beats held in a stalled pipeline.
    out_ready = 1'b0;
    a_s = 64'h11; b_s = 64'h22; ctl = 1'b0; in_valid = 1'b1;
    tick();
    a_s = 64'h33;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("flush no valid", 0, 64'(ov_a[0]), 64'd0);
      tick();
    end

    // Flush beats a simultaneous acceptance, in_ready still reported.
    flush = 1'b1;
    in_valid = 1'b1;
    a_s = 64'h44;
    #1;
    chk("flush in_ready", 0, 64'(ir_a[0]), 64'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("flush drop", 0, 64'(ov_a[0]), 64'd0);
      tick();
    end

    // Asynchronous reset between edges with a beat at the output.
    a_s = 64'h11; b_s = 64'h22; ctl = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre-rst valid", 0, 64'(ov_a[0]), 64'd1);
    #1 rst = 1'b1;
    clear_sb();
    #1;
    chk("async rst valid", 0, 64'(ov_a[0]), 64'd0);
    chk("async rst sum", 0, sum_a[0], 64'd0);
    chk("async rst ready", 0, 64'(ir_a[0]), 64'd1);
    rst = 1'b0;
    a_s = 64'h03; b_s = 64'h04; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post-rst early", 0, 64'(ov_a[0]), 64'd0);
    tick();
    chk("post-rst valid", 0, 64'(ov_a[0]), 64'd1);
    chk("post-rst sum", 0, sum_a[0], 64'h07);
    tick();

    // Random traffic with corner operands on all instances.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(99) == 0);
      ctl       = $urandom_range(1);
      a_s = pick();
      b_s = pick();
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < N; i++)
      chk("drain", i, 64'(q[i].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
